// File: rtl/gray_step_decoder.sv
// Receive-side decoder for the 3-bit Gray position code: decodes each sample to an index,
// classifies the transition, and tracks a wrapping position plus a saturating error count.
module gray_step_decoder #(
  parameter int POS_W  = 8,
  parameter int ERRC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              g_valid,
  input  logic [2:0]        g_in,
  input  logic              clr_err,
  output logic [2:0]        bin_out,
  output logic              bin_vld,
  output logic              step_up,
  output logic              step_dn,
  output logic              err,
  output logic [POS_W-1:0]  pos,
  output logic [ERRC_W-1:0] err_cnt
);

  typedef enum logic [1:0] {SYNC, TRACK, ERR} state_t;

  localparam logic signed [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic signed [POS_W-1:0] POS_MONE = {POS_W{1'b1}};

  // Source sequence is 000,010,011,001,101,111,110,100 -- not the reflected binary code.
  function automatic logic [2:0] gray_to_idx(input logic [2:0] g);
    logic [2:0] r;
    case (g)
      3'b000:  r = 3'd0;
      3'b010:  r = 3'd1;
      3'b011:  r = 3'd2;
      3'b001:  r = 3'd3;
      3'b101:  r = 3'd4;
      3'b111:  r = 3'd5;
      3'b110:  r = 3'd6;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  function automatic logic [ERRC_W-1:0] sat_inc(input logic [ERRC_W-1:0] c);
    return (c == {ERRC_W{1'b1}}) ? c : c + ERRC_W'(1);
  endfunction

  function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                        input logic up);
    return up ? p + POS_ONE : p + POS_MONE;
  endfunction

  state_t                    state_q, state_d;
  logic [2:0]                prev_q, prev_d;
  logic [2:0]                bin_out_q, bin_out_d;
  logic                      bin_vld_q, bin_vld_d;
  logic                      step_up_q, step_up_d;
  logic                      step_dn_q, step_dn_d;
  logic                      err_q, err_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic [ERRC_W-1:0]         err_cnt_q, err_cnt_d;
  logic [2:0]                idx;
  logic [2:0]                delta;

  assign idx   = gray_to_idx(g_in);
  assign delta = idx - prev_q;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    bin_out_d = bin_out_q;
    bin_vld_d = 1'b0;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    err_d     = err_q;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;

    if (g_valid) begin
      prev_d    = idx;
      bin_out_d = idx;
      bin_vld_d = 1'b1;
    end

    case (state_q)
      SYNC: begin
        if (g_valid) state_d = TRACK;
      end
      TRACK: begin
        if (g_valid) begin
          case (delta)
            3'd0: ;
            3'd1: begin
              step_up_d = 1'b1;
              pos_d     = pos_step(pos_q, 1'b1);
            end
            3'd7: begin
              step_dn_d = 1'b1;
              pos_d     = pos_step(pos_q, 1'b0);
            end
            default: begin
              err_d     = 1'b1;
              err_cnt_d = sat_inc(err_cnt_q);
              state_d   = ERR;
            end
          endcase
        end
      end
      ERR: begin
        // A simultaneous sample still updates bin_out/prev, but the next one reseeds.
        if (clr_err) begin
          err_d   = 1'b0;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      prev_q    <= '0;
      bin_out_q <= '0;
      bin_vld_q <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      bin_out_q <= bin_out_d;
      bin_vld_q <= bin_vld_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bin_out = bin_out_q;
  assign bin_vld = bin_vld_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign err     = err_q;
  assign pos     = pos_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: directed samples push expected responses,
// a negedge monitor pops one per bin_vld pulse.
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       g_valid = 1'b0;
  logic [2:0] g_in = 3'b000;
  logic       clr_err = 1'b0;
  logic [2:0] bin_out;
  logic       bin_vld;
  logic       step_up;
  logic       step_dn;
  logic       err;
  logic [7:0] pos;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  typedef struct packed {
    logic [2:0] bin;
    logic       up;
    logic       dn;
    logic       er;
    logic [7:0] p;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];
  logic [2:0] gtab [8] = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111, 3'b110, 3'b100};

  gray_step_decoder #(.POS_W(8), .ERRC_W(4)) dut (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_in(g_in), .clr_err(clr_err),
    .bin_out(bin_out), .bin_vld(bin_vld), .step_up(step_up), .step_dn(step_dn),
    .err(err), .pos(pos), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one pop per bin_vld pulse; pulses must stay low otherwise.
  always @(negedge clk) begin
    if (armed) begin
      if (bin_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld: got bin_vld=1 with no expected sample, required none");
        end else begin
          exp_t e;
          exp_t g;
          e = exp_q.pop_front();
          g = '{bin: bin_out, up: step_up, dn: step_dn, er: err, p: pos, c: err_cnt};
          if (g !== e) begin
            errors++;
            $display("FAIL sample: got bin=%0d up=%0b dn=%0b err=%0b pos=%02h cnt=%0d, required bin=%0d up=%0b dn=%0b err=%0b pos=%02h cnt=%0d",
                     g.bin, g.up, g.dn, g.er, g.p, g.c, e.bin, e.up, e.dn, e.er, e.p, e.c);
          end
        end
      end else begin
        checks++;
        if ((step_up | step_dn) !== 1'b0) begin
          errors++;
          $display("FAIL idle_pulse: got step_up=%0b step_dn=%0b, required 0 0", step_up, step_dn);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [2:0] code, input logic clr, input logic [2:0] b,
                      input logic u, input logic d, input logic e,
                      input logic [7:0] p, input logic [3:0] c);
    g_valid = 1'b1;
    g_in    = code;
    clr_err = clr;
    exp_q.push_back('{bin: b, up: u, dn: d, er: e, p: p, c: c});
    @(posedge clk);
    #1;
    g_valid = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    g_valid = 1'b0;
    clr_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {bin_out, bin_vld, step_up, step_dn, err, pos, err_cnt}, 32'd0);
    armed = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Full forward revolution
    send(3'b000, 0, 3'd0, 0, 0, 0, 8'h00, 4'd0);
    send(3'b010, 0, 3'd1, 1, 0, 0, 8'h01, 4'd0);
    send(3'b011, 0, 3'd2, 1, 0, 0, 8'h02, 4'd0);
    send(3'b001, 0, 3'd3, 1, 0, 0, 8'h03, 4'd0);
    send(3'b101, 0, 3'd4, 1, 0, 0, 8'h04, 4'd0);
    send(3'b111, 0, 3'd5, 1, 0, 0, 8'h05, 4'd0);
    send(3'b110, 0, 3'd6, 1, 0, 0, 8'h06, 4'd0);
    send(3'b100, 0, 3'd7, 1, 0, 0, 8'h07, 4'd0);
    send(3'b000, 0, 3'd0, 1, 0, 0, 8'h08, 4'd0);
    send(3'b000, 0, 3'd0, 0, 0, 0, 8'h08, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_pos", pos, 8'h08);

    // Backward steps wrapping below zero, then forward back through 0xFF -> 0x00
    do_reset();
    send(3'b000, 0, 3'd0, 0, 0, 0, 8'h00, 4'd0);
    send(3'b100, 0, 3'd7, 0, 1, 0, 8'hFF, 4'd0);
    send(3'b110, 0, 3'd6, 0, 1, 0, 8'hFE, 4'd0);
    send(3'b111, 0, 3'd5, 0, 1, 0, 8'hFD, 4'd0);
    send(3'b110, 0, 3'd6, 1, 0, 0, 8'hFE, 4'd0);
    send(3'b100, 0, 3'd7, 1, 0, 0, 8'hFF, 4'd0);
    send(3'b000, 0, 3'd0, 1, 0, 0, 8'h00, 4'd0);

    // Illegal jump 0 -> 2, then ERR ignores steps
    send(3'b011, 0, 3'd2, 0, 0, 1, 8'h00, 4'd1);
    send(3'b001, 0, 3'd3, 0, 0, 1, 8'h00, 4'd1);

    // Clear with simultaneous sample, reseed, then a real step
    send(3'b101, 1, 3'd4, 0, 0, 0, 8'h00, 4'd1);
    send(3'b111, 0, 3'd5, 0, 0, 0, 8'h00, 4'd1);
    send(3'b110, 0, 3'd6, 1, 0, 0, 8'h01, 4'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    send(3'b100, 0, 3'd7, 1, 0, 0, 8'h02, 4'd1);

    // Repeated illegal jumps 7 -> 3, saturating the counter
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      send(3'b001, 0, 3'd3, 0, 0, 1, 8'h02, c);
      send(3'b100, 1, 3'd7, 0, 0, 0, 8'h02, c);
      send(3'b100, 0, 3'd7, 0, 0, 0, 8'h02, c);
    end
    check("err_cnt_sat", err_cnt, 4'd15);
    send(3'b001, 0, 3'd3, 0, 0, 1, 8'h02, 4'd15);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("clr_alone_err", err, 1'b0);
    send(3'b001, 0, 3'd3, 0, 0, 0, 8'h02, 4'd15);
    send(3'b101, 0, 3'd4, 1, 0, 0, 8'h03, 4'd15);

    // 128 forward steps: crosses 0x7F -> 0x80
    do_reset();
    send(3'b000, 0, 3'd0, 0, 0, 0, 8'h00, 4'd0);
    for (int i = 1; i <= 128; i++) begin
      send(gtab[i % 8], 0, 3'(i % 8), 1, 0, 0, 8'(i), 4'd0);
    end
    check("pos_wrap_80", pos, 8'h80);

    // Reset mid-sequence with pos=5, err=1
    do_reset();
    send(3'b000, 0, 3'd0, 0, 0, 0, 8'h00, 4'd0);
    send(3'b010, 0, 3'd1, 1, 0, 0, 8'h01, 4'd0);
    send(3'b011, 0, 3'd2, 1, 0, 0, 8'h02, 4'd0);
    send(3'b001, 0, 3'd3, 1, 0, 0, 8'h03, 4'd0);
    send(3'b101, 0, 3'd4, 1, 0, 0, 8'h04, 4'd0);
    send(3'b111, 0, 3'd5, 1, 0, 0, 8'h05, 4'd0);
    send(3'b010, 0, 3'd1, 0, 0, 1, 8'h05, 4'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrun_reset", {bin_out, bin_vld, step_up, step_dn, err, pos, err_cnt}, 32'd0);
    send(3'b011, 0, 3'd2, 0, 0, 0, 8'h00, 4'd0);
    send(3'b001, 0, 3'd3, 1, 0, 0, 8'h01, 4'd0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
